// File: rtl/bitbang_host_if.sv
// Host-side bit-bang link for the miner.
// Deserialises 512-bit work frames (midstate, then data) from RxD/RxC/RxTxR.
// Queues golden nonces from the core and serialises them, LSB byte first,
// over TxD. Each transmitted byte is preceded by a marker bit, one bit per TxC edge.
module bitbang_host_if #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          RxD,
  input  logic                          RxC,
  input  logic                          RxTxR,
  input  logic                          TxC,
  output logic                          TxD,
  output logic [255:0]                  midstate,
  output logic [255:0]                  data,
  output logic                          work_valid,
  output logic                          frame_err,
  input  logic [31:0]                   nonce_in,
  input  logic                          nonce_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_BITS = 1'b1
  } tx_state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers and rising-edge detection
  // Bit order in the packed vectors: {TxC, RxTxR, RxC, RxD}.
  // ---------------------------------------------------------------------------
  logic [3:0] pins_s;
  logic [3:0] sync_r [SYNC_STAGES];
  logic [3:0] dly_r;
  logic [2:0] rise_r;
  logic       rxd_s;
  logic       rxc_rise_s;
  logic       rxtxr_rise_s;
  logic       txc_rise_s;

  assign pins_s       = {TxC, RxTxR, RxC, RxD};
  assign rxd_s        = dly_r[0];
  assign rxc_rise_s   = rise_r[0];
  assign rxtxr_rise_s = rise_r[1];
  assign txc_rise_s   = rise_r[2];

  // Synchronise host pins, delay RxD to stay aligned with the RxC edge pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= 4'd0;
      end
      dly_r  <= 4'd0;
      rise_r <= 3'd0;
    end else begin
      sync_r[0] <= pins_s;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      dly_r  <= sync_r[SYNC_STAGES-1];
      rise_r <= sync_r[SYNC_STAGES-1][3:1] & ~dly_r[3:1];
    end
  end

  // ---------------------------------------------------------------------------
  // Receive path
  // ---------------------------------------------------------------------------
  logic [7:0]   byte_r;
  logic [7:0]   byte_s;
  logic [9:0]   bit_cnt_r;
  logic [511:0] sr_r;

  assign byte_s = {rxd_s, byte_r[7:1]};

  // Shift in RxC bits, assemble bytes, and commit or reject the frame on RxTxR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_r     <= 8'd0;
      bit_cnt_r  <= 10'd0;
      sr_r       <= 512'd0;
      midstate   <= 256'd0;
      data       <= 256'd0;
      work_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      work_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (rxtxr_rise_s) begin
        // A coincident RxC bit is dropped: the frame strobe takes priority.
        if (bit_cnt_r == 10'd512) begin
          midstate   <= sr_r[511:256];
          data       <= sr_r[255:0];
          work_valid <= 1'b1;
        end else if (bit_cnt_r != 10'd0) begin
          frame_err <= 1'b1;
        end
        bit_cnt_r <= 10'd0;
        byte_r    <= 8'd0;
      end else if (rxc_rise_s) begin
        byte_r <= byte_s;
        if (bit_cnt_r != 10'd513) begin
          bit_cnt_r <= bit_cnt_r + 10'd1;
        end
        // Once the counter passes 512 the frame is doomed, so stop shifting.
        if ((bit_cnt_r[2:0] == 3'd7) && (bit_cnt_r < 10'd512)) begin
          sr_r <= {sr_r[503:0], byte_s};
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Golden-nonce FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          full_s;
  logic          empty_s;
  logic          push_ok_s;
  logic          pop_s;
  logic [31:0]   head_s;

  assign full_s     = (count_r == CW'(FIFO_DEPTH));
  assign empty_s    = (count_r == CW'(0));
  // When full, a push is still taken if the head leaves in the same cycle.
  assign push_ok_s  = nonce_valid && (!full_s || pop_s);
  assign head_s     = mem_r[rd_ptr_r];
  assign fifo_count = count_r;

  // Nonce storage; contents are qualified by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= nonce_in;
    end
  end

  // FIFO pointers, occupancy and saturating drop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      drop_count <= 8'd0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (nonce_valid && !push_ok_s && (drop_count != 8'd255)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  tx_state_t state_r;
  tx_state_t state_s;
  logic [2:0] bit_idx_r;
  logic [2:0] bit_idx_s;
  logic [1:0] byte_idx_r;
  logic [1:0] byte_idx_s;
  logic       txd_r;
  logic       txd_s;

  assign TxD = txd_r;

  // Transmit state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= TX_IDLE;
      bit_idx_r  <= 3'd0;
      byte_idx_r <= 2'd0;
      txd_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      bit_idx_r  <= bit_idx_s;
      byte_idx_r <= byte_idx_s;
      txd_r      <= txd_s;
    end
  end

  // Next-state logic: marker, then 8 data bits per byte; RxTxR aborts to byte 0.
  always_comb begin
    state_s    = state_r;
    bit_idx_s  = bit_idx_r;
    byte_idx_s = byte_idx_r;
    txd_s      = txd_r;
    pop_s      = 1'b0;
    if (rxtxr_rise_s) begin
      state_s    = TX_IDLE;
      bit_idx_s  = 3'd0;
      byte_idx_s = 2'd0;
      txd_s      = 1'b0;
    end else if (txc_rise_s) begin
      case (state_r)
        TX_IDLE: begin
          if (!empty_s) begin
            txd_s     = 1'b1;
            state_s   = TX_BITS;
            bit_idx_s = 3'd0;
          end else begin
            txd_s = 1'b0;
          end
        end
        TX_BITS: begin
          txd_s     = head_s[{byte_idx_r, bit_idx_r}];
          bit_idx_s = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) begin
            state_s = TX_IDLE;
            // byte_idx wraps from 3 back to 0 as the head is retired.
            byte_idx_s = byte_idx_r + 2'd1;
            if (byte_idx_r == 2'd3) begin
              pop_s = 1'b1;
            end else begin
              pop_s = 1'b0;
            end
          end else begin
            state_s = TX_BITS;
          end
        end
        default: begin
          state_s    = TX_IDLE;
          bit_idx_s  = 3'd0;
          byte_idx_s = 2'd0;
          txd_s      = 1'b0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

endmodule

// File: tb/tb_bitbang_host_if.sv
// Randomised scoreboard bench for bitbang_host_if.
// Frames and TxC polls push expected results into queues.
// A negedge monitor pops and compares whenever work_valid/frame_err pulse or a TxD update falls due.
module tb_bitbang_host_if;

  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int HOLD  = 5;

  localparam logic [255:0] PLAN_MS =
    256'h2b3f8126_01234567_89abcdef_01234567_89abcdef_01234567_89abcdef_2619c0b5;
  localparam logic [255:0] PLAN_DS =
    256'hfedcba98_76543210_fedcba98_76543210_fedcba98_39f3001b_6b7b8d4d_c14bfc31;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         RxD = 1'b0;
  logic         RxC = 1'b0;
  logic         RxTxR = 1'b0;
  logic         TxC = 1'b0;
  logic         TxD;
  logic [255:0] midstate;
  logic [255:0] data;
  logic         work_valid;
  logic         frame_err;
  logic [31:0]  nonce_in = 32'd0;
  logic         nonce_valid = 1'b0;
  logic [2:0]   fifo_count;
  logic [7:0]   drop_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bitbang_host_if #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .RxD(RxD), .RxC(RxC), .RxTxR(RxTxR), .TxC(TxC),
    .TxD(TxD), .midstate(midstate), .data(data), .work_valid(work_valid),
    .frame_err(frame_err), .nonce_in(nonce_in), .nonce_valid(nonce_valid),
    .fifo_count(fifo_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic         err;
    logic [255:0] ms;
    logic [255:0] d;
  } fexp_t;

  typedef struct packed {
    logic [31:0] due;
    logic        v;
  } texp_t;

  fexp_t frame_q[$];
  texp_t tx_q[$];

  // Reference model state
  logic [31:0]  m_fifo[$];
  int           m_pos  = 0;
  int           m_drop = 0;
  logic         rx_bits[$];
  logic [255:0] m_ms = 256'd0;
  logic [255:0] m_d  = 256'd0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  fexp_t mon_e;
  texp_t mon_t;

  // Monitor: pop expectations whenever the DUT presents a frame result or a TxD update.
  always @(negedge clk) begin
    if (!reset) begin
      if (work_valid || frame_err) begin
        if (frame_q.size() == 0) begin
          check("unexpected_frame_pulse", 512'({work_valid, frame_err}), 512'd0);
        end else begin
          mon_e = frame_q.pop_front();
          check("frame_kind", 512'({work_valid, frame_err}), 512'({!mon_e.err, mon_e.err}));
          check("midstate", 512'(midstate), 512'(mon_e.ms));
          check("data", 512'(data), 512'(mon_e.d));
        end
      end
      while ((tx_q.size() != 0) && (tx_q[0].due <= 32'(cyc))) begin
        mon_t = tx_q.pop_front();
        check("txd", 512'(TxD), 512'(mon_t.v));
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    RxD = b;
    rx_bits.push_back(b);
    wait_cyc(HOLD);
    RxC = 1'b1;
    wait_cyc(HOLD);
    RxC = 1'b0;
  endtask

  // Bytes go out most-significant byte of the word first, each LSB-first.
  task automatic send_bytes(input logic [511:0] w, input int nbytes);
    logic [7:0] by;
    for (int k = 0; k < nbytes; k++) begin
      if (k < 64) by = w[511 - 8*k -: 8];
      else        by = 8'hA5;
      for (int j = 0; j < 8; j++) send_bit(by[j]);
    end
  endtask

  task automatic pulse_sync();
    fexp_t e;
    logic [511:0] word;
    word = 512'd0;
    if (rx_bits.size() == 512) begin
      for (int i = 0; i < 512; i++) word[504 - 8*(i/8) + (i%8)] = rx_bits[i];
      m_ms = word[511:256];
      m_d  = word[255:0];
      e.err = 1'b0; e.ms = m_ms; e.d = m_d;
      frame_q.push_back(e);
    end else if (rx_bits.size() != 0) begin
      e.err = 1'b1; e.ms = m_ms; e.d = m_d;
      frame_q.push_back(e);
    end
    rx_bits.delete();
    m_pos = 0;
    RxTxR = 1'b1;
    wait_cyc(HOLD);
    RxTxR = 1'b0;
    wait_cyc(HOLD);
  endtask

  // One TxC poll: model says marker / data bit / idle-zero by symbol position.
  task automatic poll_tx();
    texp_t t;
    logic v;
    logic [31:0] head;
    int byt;
    int b;
    if (m_fifo.size() == 0) begin
      v = 1'b0;
    end else begin
      head = m_fifo[0];
      byt  = m_pos / 9;
      b    = m_pos % 9;
      v    = (b == 0) ? 1'b1 : head[8*byt + b - 1];
      m_pos++;
      if (m_pos == 36) begin
        void'(m_fifo.pop_front());
        m_pos = 0;
      end
    end
    TxC   = 1'b1;
    t.due = 32'(cyc + SYNC + 2);
    t.v   = v;
    tx_q.push_back(t);
    wait_cyc(HOLD);
    TxC = 1'b0;
    wait_cyc(HOLD);
  endtask

  task automatic push_nonce(input logic [31:0] v);
    nonce_in    = v;
    nonce_valid = 1'b1;
    if (m_fifo.size() < DEPTH) m_fifo.push_back(v);
    else if (m_drop < 255)     m_drop++;
    wait_cyc(1);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_fifo_count"}, 512'(fifo_count), 512'(m_fifo.size()));
    check({tag, "_drop_count"}, 512'(drop_count), 512'(m_drop));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_txd"}, 512'(TxD), 512'd0);
    check({tag, "_pulses"}, 512'({work_valid, frame_err}), 512'd0);
    check({tag, "_midstate"}, 512'(midstate), 512'd0);
    check({tag, "_data"}, 512'(data), 512'd0);
    check({tag, "_fifo_count"}, 512'(fifo_count), 512'd0);
    check({tag, "_drop_count"}, 512'(drop_count), 512'd0);
  endtask

  function automatic logic [511:0] rand_word();
    logic [511:0] w;
    for (int i = 0; i < 16; i++) w[32*i +: 32] = $urandom();
    return w;
  endfunction

  initial begin
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(2);
    check_reset_vals("reset");

    // Known frame after a sync-only pulse
    pulse_sync();
    send_bytes({PLAN_MS, PLAN_DS}, 64);
    pulse_sync();
    wait_cyc(4);
    check("plan_midstate", 512'(midstate), 512'(PLAN_MS));
    check("plan_data", 512'(data), 512'(PLAN_DS));

    // Short frame is rejected, next full frame accepted
    send_bytes(rand_word(), 63);
    pulse_sync();
    send_bytes(rand_word(), 64);
    pulse_sync();

    // Single nonce readback
    push_nonce(32'h01D00BDC);
    nonce_valid = 1'b0;
    check_counts("one_push");
    for (int i = 0; i < 36; i++) poll_tx();
    check_counts("one_drained");

    // Empty FIFO polling
    for (int i = 0; i < 8; i++) poll_tx();

    // Overfill: 6 back-to-back pushes into 4 entries
    for (int i = 0; i < 6; i++) push_nonce($urandom());
    nonce_valid = 1'b0;
    check_counts("overfill");
    for (int i = 0; i < 4 * 36; i++) poll_tx();
    check_counts("overfill_drained");

    // Abort mid-nonce: head resent from byte 0
    push_nonce($urandom());
    nonce_valid = 1'b0;
    for (int i = 0; i < 13; i++) poll_tx();
    pulse_sync();
    for (int i = 0; i < 36; i++) poll_tx();
    check_counts("abort");

    // Drop counter saturation
    for (int i = 0; i < 264; i++) push_nonce($urandom());
    nonce_valid = 1'b0;
    check_counts("saturate");

    // Reset mid-nonce and mid-frame
    for (int i = 0; i < 18; i++) poll_tx();
    send_bytes(rand_word(), 20);
    reset = 1'b1;
    m_fifo.delete();
    m_pos  = 0;
    m_drop = 0;
    rx_bits.delete();
    m_ms = 256'd0;
    m_d  = 256'd0;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(2);
    check_reset_vals("midreset");

    // Post-reset frame and nonce readback
    send_bytes(rand_word(), 64);
    pulse_sync();
    push_nonce($urandom());
    push_nonce($urandom());
    nonce_valid = 1'b0;
    for (int i = 0; i < 72; i++) poll_tx();
    check_counts("post_reset");

    // Randomised frames of 63/64/65 bytes interleaved with nonce traffic
    for (int r = 0; r < 3; r++) begin
      int nb;
      int np;
      nb = 63 + $urandom_range(0, 2);
      send_bytes(rand_word(), nb);
      pulse_sync();
      np = $urandom_range(1, 3);
      for (int i = 0; i < np; i++) push_nonce($urandom());
      nonce_valid = 1'b0;
      check_counts("rand_push");
      for (int i = 0; i < np * 36 + 2; i++) poll_tx();
      check_counts("rand_drain");
    end

    wait_cyc(20);
    check("frame_q_left", 512'(frame_q.size()), 512'd0);
    check("tx_q_left", 512'(tx_q.size()), 512'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
